// File: rtl/pp_fifo_arb.sv
// Two-requester arbiter feeding an external FIFO, with a 2-entry read buffer.
// Define PP_FIFO_ARB_RR_EN for round-robin grant; otherwise s0 has fixed priority.
module pp_fifo_arb #(
    parameter int DW         = 8,
    parameter int RST_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s0_data,
    input  logic          s0_valid,
    output logic          s0_ready,
    input  logic [DW-1:0] s1_data,
    input  logic          s1_valid,
    output logic          s1_ready,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    input  logic          flush,
    output logic [DW-1:0] fifo_di,
    output logic          fifo_we,
    output logic          fifo_re,
    input  logic [DW-1:0] fifo_do,
    output logic          fifo_rst,
    input  logic          fifo_empty,
    input  logic          fifo_full
);

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [3:0] CNT_INIT = 4'(RST_CYCLES);

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          run;
    logic          enter_flush;
    logic          open;
    logic          g0;
    logic          g1;
    logic          re_q;
    logic [1:0]    count;
    logic [DW-1:0] b0;
    logic [DW-1:0] b1;
    logic          push;
    logic          pop;

    assign run         = (state == ST_RUN);
    assign enter_flush = run & flush;
    assign fifo_rst    = ~run;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_INIT;
            cnt   <= CNT_INIT;
        end else begin
            case (state)
                ST_RUN: begin
                    if (flush) begin
                        state <= ST_FLUSH;
                        cnt   <= CNT_INIT;
                    end
                end
                default: begin
                    if (flush) begin
                        cnt <= CNT_INIT;
                    end else if (cnt == 4'd1) begin
                        state <= ST_RUN;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
            endcase
        end
    end

    assign open = run & ~fifo_full;

`ifdef PP_FIFO_ARB_RR_EN
    logic ptr;

    // ptr=0 favours s0; it moves on only after the favoured side wins
    assign g0 = open & s0_valid & (~s1_valid | ~ptr);
    assign g1 = open & s1_valid & (~s0_valid | ptr);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= 1'b0;
        end else if ((g0 & ~ptr) | (g1 & ptr)) begin
            ptr <= ~ptr;
        end
    end
`else
    assign g0 = open & s0_valid;
    assign g1 = open & s1_valid & ~s0_valid;
`endif

    assign s0_ready = g0;
    assign s1_ready = g1;
    assign fifo_we  = (s0_valid & s0_ready) | (s1_valid & s1_ready);
    assign fifo_di  = g1 ? s1_data : (g0 ? s0_data : '0);

    // one read in flight at most, so the buffer can never overflow
    assign fifo_re = run & ~fifo_empty & ~re_q & (count != 2'd2);
    assign m_valid = run & (count != 2'd0);
    assign m_data  = b0;
    assign push    = re_q & run & ~flush;
    assign pop     = m_valid & m_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            re_q  <= 1'b0;
            count <= 2'd0;
            b0    <= '0;
            b1    <= '0;
        end else begin
            re_q <= fifo_re;
            if (enter_flush) begin
                count <= 2'd0;
            end else begin
                case ({push, pop})
                    2'b10: begin
                        if (count == 2'd0) b0 <= fifo_do;
                        else b1 <= fifo_do;
                        count <= count + 2'd1;
                    end
                    2'b01: begin
                        b0    <= b1;
                        count <= count - 2'd1;
                    end
                    2'b11: begin
                        if (count == 2'd1) begin
                            b0 <= fifo_do;
                        end else begin
                            b0 <= b1;
                            b1 <= fifo_do;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pp_fifo_arb.sv
// Randomized bench for pp_fifo_arb against a queue-based reference model,
// with a behavioural external FIFO and directed boundary scenarios.
module tb_pp_fifo_arb;

    localparam int DW    = 8;
    localparam int RC    = 4;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] s0_data = '0;
    logic          s0_valid = 1'b0;
    logic          s0_ready;
    logic [DW-1:0] s1_data = '0;
    logic          s1_valid = 1'b0;
    logic          s1_ready;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          flush = 1'b0;
    logic [DW-1:0] fifo_di;
    logic          fifo_we;
    logic          fifo_re;
    logic [DW-1:0] fifo_do = '0;
    logic          fifo_rst;
    logic          fifo_empty = 1'b1;
    logic          fifo_full = 1'b0;

    always #5 clk = ~clk;

    pp_fifo_arb #(.DW(DW), .RST_CYCLES(RC)) dut (
        .clk(clk), .rst(rst),
        .s0_data(s0_data), .s0_valid(s0_valid), .s0_ready(s0_ready),
        .s1_data(s1_data), .s1_valid(s1_valid), .s1_ready(s1_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .flush(flush),
        .fifo_di(fifo_di), .fifo_we(fifo_we), .fifo_re(fifo_re),
        .fifo_do(fifo_do), .fifo_rst(fifo_rst),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full)
    );

    int n_cmp = 0;
    int n_err = 0;

    // reference model: cycles of reset left, buffer and FIFO as queues
    int            rst_left;
    logic [DW-1:0] bq[$];
    logic [DW-1:0] fq[$];
    bit            infl;
    bit            fav;
    int            e_g;
    logic [DW-1:0] di_log[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        rst_left = RC;
        bq.delete();
        fq.delete();
        infl     = 1'b0;
        fav      = 1'b0;
        fifo_do  = '0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_rst"}, fifo_rst, 1);
        chk({tag, "_rdy0"}, s0_ready, 0);
        chk({tag, "_rdy1"}, s1_ready, 0);
        chk({tag, "_we"}, fifo_we, 0);
        chk({tag, "_re"}, fifo_re, 0);
        chk({tag, "_mv"}, m_valid, 0);
        chk({tag, "_md"}, m_data, 0);
        chk({tag, "_di"}, fifo_di, 0);
    endtask

    // one clock: drive at negedge, check mid-cycle, advance model after posedge
    task automatic cycle(input bit v0, input logic [DW-1:0] d0,
                         input bit v1, input logic [DW-1:0] d1,
                         input bit mr, input bit fl, input bit ff);
        bit            run;
        bit            e_we;
        bit            e_re;
        bit            e_mv;
        int            g;
        logic [DW-1:0] e_di;
        logic [DW-1:0] old_do;
        @(negedge clk);
        s0_valid   = v0;
        s0_data    = d0;
        s1_valid   = v1;
        s1_data    = d1;
        m_ready    = mr;
        flush      = fl;
        fifo_full  = ff || (fq.size() >= DEPTH);
        fifo_empty = (fq.size() == 0);
        #1;
        run = (rst_left == 0);
        g   = -1;
        if (run && !fifo_full) begin
            if (v0 && v1) begin
`ifdef PP_FIFO_ARB_RR_EN
                g = int'(fav);
`else
                g = 0;
`endif
            end else if (v0) begin
                g = 0;
            end else if (v1) begin
                g = 1;
            end
        end
        e_we = (g >= 0);
        e_di = (g == 1) ? d1 : d0;
        e_re = run && fq.size() > 0 && !infl && bq.size() < 2;
        e_mv = run && bq.size() > 0;
        chk("fifo_rst", fifo_rst, !run);
        chk("s0_ready", s0_ready, g == 0);
        chk("s1_ready", s1_ready, g == 1);
        chk("fifo_we", fifo_we, e_we);
        if (e_we) chk("fifo_di", fifo_di, e_di);
        chk("fifo_re", fifo_re, e_re);
        chk("m_valid", m_valid, e_mv);
        if (e_mv) chk("m_data", m_data, bq[0]);
        if (fifo_we) di_log.push_back(fifo_di);
        e_g = g;
        @(posedge clk);
        #1;
        old_do = fifo_do;
        if (run && fl) begin
            bq.delete();
        end else begin
            if (e_mv && mr) void'(bq.pop_front());
            if (infl && run) bq.push_back(old_do);
        end
        if (e_re) fifo_do = fq.pop_front();
        if (e_we) fq.push_back(e_di);
        if (!run) fq.delete();
        infl = e_re;
        if (run) rst_left = fl ? RC : 0;
        else rst_left = fl ? RC : rst_left - 1;
`ifdef PP_FIFO_ARB_RR_EN
        if (g >= 0 && g == int'(fav)) fav = !fav;
`endif
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cycle($urandom_range(1, 0) == 1, DW'($urandom),
                  $urandom_range(1, 0) == 1, DW'($urandom),
                  $urandom_range(3, 0) != 0,
                  $urandom_range(63, 0) == 0,
                  $urandom_range(7, 0) == 0);
        end
    endtask

    initial begin
        logic [DW-1:0] exp_ord [4];
        int            i0;
        int            i1;
        bit            found;

        model_reset();
        #1;
        chk_reset_outs("por");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // init window, then s0 alone is accepted immediately
        repeat (RC + 2) cycle(0, '0, 0, '0, 1, 0, 0);
        cycle(1, 8'h33, 0, '0, 1, 0, 0);

        // arbitration order with both requesters valid
        di_log.delete();
        i0 = 0;
        i1 = 0;
        for (int k = 0; k < 4; k++) begin
            cycle(1, DW'(8'h10 + i0), 1, DW'(8'h20 + i1), 1, 0, 0);
            if (e_g == 0) i0++;
            else if (e_g == 1) i1++;
        end
`ifdef PP_FIFO_ARB_RR_EN
        exp_ord = '{8'h10, 8'h20, 8'h11, 8'h21};
`else
        exp_ord = '{8'h10, 8'h11, 8'h12, 8'h13};
`endif
        chk("arb_cnt", di_log.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk("arb_order", (k < di_log.size()) ? di_log[k] : 'x, exp_ord[k]);
        end
        repeat (30) cycle(0, '0, 0, '0, 1, 0, 0);

        // full blocks both, write resumes the cycle full drops
        cycle(1, 8'h44, 1, 8'h55, 1, 0, 1);
        cycle(1, 8'h44, 1, 8'h55, 1, 0, 0);
        repeat (30) cycle(0, '0, 0, '0, 1, 0, 0);

        // buffer fills to 2 with consumer stalled, then drains in order
        cycle(1, 8'hA5, 0, '0, 0, 0, 0);
        cycle(1, 8'h5A, 0, '0, 0, 0, 0);
        cycle(1, 8'hC3, 0, '0, 0, 0, 0);
        repeat (8) cycle(0, '0, 0, '0, 0, 0, 0);
        chk("hold_re", fifo_re, 0);
        chk("hold_head", m_data, 8'hA5);
        cycle(0, '0, 0, '0, 1, 0, 0);
        chk("pop_next", m_data, 8'h5A);
        repeat (30) cycle(0, '0, 0, '0, 1, 0, 0);

        // flush the cycle after a read with one word already buffered
        cycle(1, 8'h61, 0, '0, 0, 0, 0);
        cycle(1, 8'h62, 0, '0, 0, 0, 0);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            cycle(0, '0, 0, '0, 0, 0, 0);
            found = infl && bq.size() == 1;
        end
        chk("flush_setup", found, 1);
        cycle(0, '0, 0, '0, 0, 1, 0);
        chk("flush_mv", m_valid, 0);
        chk("flush_rst", fifo_rst, 1);
        repeat (RC + 2) cycle(0, '0, 0, '0, 1, 0, 0);
        chk("flush_drop", m_valid, 0);

        rand_cycles(3000);

        // asynchronous reset in mid-cycle while traffic is active
        @(negedge clk);
        s0_valid   = 1'b1;
        s1_valid   = 1'b1;
        m_ready    = 1'b1;
        fifo_empty = 1'b0;
        fifo_full  = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outs("async");
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        rand_cycles(200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pp_fifo_arb.md
PP_FIFO_ARB -- requirements
Module: pp_fifo_arb

Interface
REQ-001 Parameter DW, default 8: data width of both requesters, consumer and FIFO.
REQ-002 Parameter RST_CYCLES, default 4, range 1-15: cycles fifo_rst is held high for init and flush.
REQ-003 clk  input  1  single clock for all logic; also drives the FIFO's clkw and clkr.
REQ-004 rst  input  1  reset, asynchronous, active-low; low forces the reset state immediately; release is sampled on clk.
REQ-005 s0_data  input  DW  requester 0 write data.
REQ-006 s0_valid  input  1  requester 0 has a word.
REQ-007 s0_ready  output  1  requester 0 word accepted this cycle when s0_valid is also high.
REQ-008 s1_data, s1_valid, s1_ready  as s0_*, for requester 1.
REQ-009 m_data  output  DW  consumer data, head of the read buffer.
REQ-010 m_valid  output  1  m_data valid.
REQ-011 m_ready  input  1  consumer accepts m_data.
REQ-012 flush  input  1  single-cycle request to discard all FIFO and buffer contents.
REQ-013 fifo_di  output  DW  FIFO write data.
REQ-014 fifo_we  output  1  FIFO write enable.
REQ-015 fifo_re  output  1  FIFO read enable.
REQ-016 fifo_do  input  DW  FIFO read data, valid the cycle after fifo_re.
REQ-017 fifo_rst  output  1  FIFO synchronous active-high reset, also drives rprst.
REQ-018 fifo_empty, fifo_full  input  1  FIFO flags.

Function
REQ-019 FSM states: INIT, RUN, FLUSH; a counter of at least 4 bits times RST_CYCLES.
REQ-020 INIT: fifo_rst=1 for RST_CYCLES cycles after reset release, then RUN.
REQ-021 RUN with flush=1: next state FLUSH, counter reloaded; FLUSH holds fifo_rst=1 for RST_CYCLES cycles, then RUN.
REQ-022 flush during INIT or FLUSH restarts the counter and keeps the current state.
REQ-023 Outside RUN: s0_ready=s1_ready=0, fifo_we=0, fifo_re=0, m_valid=0.
REQ-024 In RUN with fifo_full=0, exactly one valid requester is granted; s_ready is combinational; zero-latency path s_data to fifo_di.
REQ-025 fifo_we = (s0_valid&s0_ready)|(s1_valid&s1_ready); fifo_di = data of the granted requester; no write when fifo_full=1.
REQ-026 Read buffer: 2 entries, FIFO order, count 0-2; m_valid = (count!=0); m_data = oldest entry.
REQ-027 fifo_re=1 only when: RUN, fifo_empty=0, fifo_re was 0 the previous cycle, and count<2.
REQ-028 The cycle after fifo_re=1, fifo_do is written into the buffer, unless FLUSH was entered in that cycle, in which case the word is dropped.
REQ-029 Push and pop (m_valid&m_ready) in the same cycle leave count unchanged and preserve order.
REQ-030 Entering FLUSH clears the buffer (count=0) on the transition edge.
REQ-031 Peak read throughput is 1 word per 2 cycles; peak write throughput is 1 word per cycle.

Reset
REQ-032 While rst=0: state=INIT, counter=RST_CYCLES, fifo_rst=1, count=0, all other outputs 0, RR pointer favours s0.

Configuration
REQ-033 Macro PP_FIFO_ARB_RR_EN defined: round-robin grant; the pointer toggles to the other requester after each grant to the current one.
REQ-034 Macro PP_FIFO_ARB_RR_EN undefined: fixed priority, s0 wins every conflict, no pointer state.

Verification
REQ-035 Release rst, idle inputs -> fifo_rst=1 for exactly 4 cycles, then s_ready follows s_valid.
REQ-036 RR build, both valid for 4 cycles, s0=0x10.., s1=0x20.. -> fifo_di order 0x10,0x20,0x11,0x21; fixed build -> 0x10..0x13.
REQ-037 fifo_full=1 with both valid -> s0_ready=s1_ready=fifo_we=0; full drops -> a write occurs that same cycle.
REQ-038 Write 0xA5,0x5A; m_ready=0 -> count reaches 2, fifo_re stops; m_ready=1 -> m_data 0xA5 then 0x5A, no loss or duplication.
REQ-039 flush in the cycle after fifo_re with 1 word buffered -> m_valid=0 next cycle, fifo_rst=1 for 4 cycles, in-flight word dropped.
REQ-040 rst asserted mid-transfer -> all outputs reach REQ-032 values without a clock edge.
